// File: rtl/io_pkg.sv
// Shared IO-space definitions: word addresses of the read-side registers
// and the value returned for reads that hit nothing.
package io_pkg;

    // IO word addresses
    localparam int unsigned IO_ADDR_LEDS   = 0;  // LED register, write-only
    localparam int unsigned IO_ADDR_SW     = 1;  // debounced switches
    localparam int unsigned IO_ADDR_BTN    = 2;  // debounced buttons
    localparam int unsigned IO_ADDR_BTNEVT = 3;  // sticky button-press flags
    localparam int unsigned IO_ADDR_TICK   = 4;  // free-running cycle counter

    // Read data for reserved and unmapped addresses
    localparam logic [31:0] IO_RD_MISS = 32'h0000_0000;

endpackage

// File: rtl/io_debounce.sv
// Input conditioner for a vector of raw asynchronous levels: a 2-flop
// synchronizer per bit followed by a per-bit stability counter. A bit of
// 'stable' follows its synchronized input only after the two have disagreed
// for DEB_CYCLES consecutive cycles; shorter glitches are discarded.
module io_debounce #(
    parameter int unsigned W          = 8,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    // Counter only has to reach DEB_CYCLES-1
    localparam int unsigned   CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  meta_q;
    logic [W-1:0]  sync_q;
    logic [W-1:0]  stable_q;
    logic [W-1:0]  stable_d;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];

    // Two-stage synchronizer for the raw levels
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Per-bit debounce: count mismatch cycles, commit on the last one,
    // any agreeing cycle restarts the count
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_d[i] = '0;
        end
        for (int unsigned i = 0; i < W; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stable_q <= '0;
            for (int unsigned i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int unsigned i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_input_port.sv
// Read-side responder of the IO space. Requests are registered for one
// cycle, then a read hit loads IO_RD with the selected source on the next
// edge. Sources: debounced switches, debounced buttons, sticky button-press
// flags (read-to-clear / write-1-to-clear) and a loadable cycle counter.
module io_input_port
    import io_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 14,
    parameter int unsigned N_SW       = 8,
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 DBE,
    input  logic                 IO_REQ,
    input  logic                 IO_WE,
    input  logic                 IO_RE,
    input  logic [RAM_DEPTH-1:0] IO_ADDR,
    input  logic [31:0]          IO_WD,
    input  logic [N_SW-1:0]      SW,
    input  logic [N_BTN-1:0]     BTN,
    output logic [31:0]          IO_RD
);

    localparam logic [RAM_DEPTH-1:0] A_LEDS   = RAM_DEPTH'(IO_ADDR_LEDS);
    localparam logic [RAM_DEPTH-1:0] A_SW     = RAM_DEPTH'(IO_ADDR_SW);
    localparam logic [RAM_DEPTH-1:0] A_BTN    = RAM_DEPTH'(IO_ADDR_BTN);
    localparam logic [RAM_DEPTH-1:0] A_BTNEVT = RAM_DEPTH'(IO_ADDR_BTNEVT);
    localparam logic [RAM_DEPTH-1:0] A_TICK   = RAM_DEPTH'(IO_ADDR_TICK);

    // Registered request
    logic                 ioreq_q;
    logic                 dbe_q;
    logic                 iowe_q;
    logic                 iore_q;
    logic [RAM_DEPTH-1:0] addr_q;
    logic [31:0]          wd_q;

    logic                 req_valid;
    logic                 rd_hit;
    logic                 wr_hit;

    // Conditioned inputs
    logic [N_SW-1:0]      sw_deb;
    logic [N_BTN-1:0]     btn_deb;
    logic [N_BTN-1:0]     btn_deb_prev_q;
    logic [N_BTN-1:0]     btn_rise;

    // Read-side state
    logic [N_BTN-1:0]     btn_evt_q;
    logic [N_BTN-1:0]     btn_evt_d;
    logic [N_BTN-1:0]     btn_evt_clr;
    logic [31:0]          tick_q;
    logic [31:0]          tick_d;
    logic [31:0]          rd_q;
    logic [31:0]          rd_sel;

    io_debounce #(
        .W          (N_SW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_deb (
        .CLK    (CLK),
        .RESET  (RESET),
        .raw    (SW),
        .stable (sw_deb)
    );

    io_debounce #(
        .W          (N_BTN),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .CLK    (CLK),
        .RESET  (RESET),
        .raw    (BTN),
        .stable (btn_deb)
    );

    // Capture the CPU request; it is acted on one edge later
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ioreq_q <= 1'b0;
            dbe_q   <= 1'b0;
            iowe_q  <= 1'b0;
            iore_q  <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            ioreq_q <= IO_REQ;
            dbe_q   <= DBE;
            iowe_q  <= IO_WE;
            iore_q  <= IO_RE;
            addr_q  <= IO_ADDR;
            wd_q    <= IO_WD;
        end
    end

    // A bus error cancels every effect of the request it accompanies
    assign req_valid = ioreq_q & ~dbe_q;
    assign rd_hit    = req_valid & iore_q;
    assign wr_hit    = req_valid & iowe_q;

    // Read mux; btn_evt and tick are sampled before this edge's update
    always_comb begin
        rd_sel = IO_RD_MISS;
        case (addr_q)
            A_LEDS:   rd_sel = IO_RD_MISS;
            A_SW:     rd_sel = 32'(sw_deb);
            A_BTN:    rd_sel = 32'(btn_deb);
            A_BTNEVT: rd_sel = 32'(btn_evt_q);
            A_TICK:   rd_sel = tick_q;
            default:  rd_sel = IO_RD_MISS;
        endcase
    end

    // Sticky press flags: clears from read and W1C writes merge, and a
    // rising edge in the same cycle overrides the clear
    always_comb begin
        btn_rise    = btn_deb & ~btn_deb_prev_q;
        btn_evt_clr = '0;
        if (addr_q == A_BTNEVT) begin
            if (rd_hit) begin
                btn_evt_clr = '1;
            end
            if (wr_hit) begin
                btn_evt_clr = btn_evt_clr | wd_q[N_BTN-1:0];
            end
        end
        btn_evt_d = (btn_evt_q & ~btn_evt_clr) | btn_rise;
    end

    // Cycle counter: free-running, wraps naturally, loadable by write
    always_comb begin
        tick_d = tick_q + 32'd1;
        if (wr_hit && (addr_q == A_TICK)) begin
            tick_d = wd_q;
        end
    end

    // Read-side state registers; IO_RD only moves on a read hit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_q           <= '0;
            btn_evt_q      <= '0;
            btn_deb_prev_q <= '0;
            tick_q         <= '0;
        end else begin
            if (rd_hit) begin
                rd_q <= rd_sel;
            end
            btn_evt_q      <= btn_evt_d;
            btn_deb_prev_q <= btn_deb;
            tick_q         <= tick_d;
        end
    end

    assign IO_RD = rd_q;

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Read-side responder of the IO space: returns 32-bit data on IO_RD for CPU IO loads.
- Sources: debounced switches, debounced buttons, sticky button-press capture, free-running cycle counter.
- Complements the LED write path: same request signals, same one-cycle request registration, same DBE suppression.
- Sits beside the IO write decoder; its IO_RD feeds the CPU load mux.

Parameters:
- RAM_DEPTH, 14, width of IO_ADDR.
- N_SW, 8, number of switch inputs (1..32).
- N_BTN, 4, number of button inputs (1..32).
- DEB_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (>=2).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- DBE  in  1  data bus error; the request in the same cycle is ignored.
- IO_REQ  in  1  IO-space access request.
- IO_WE  in  1  write strobe.
- IO_RE  in  1  read strobe.
- IO_ADDR  in  RAM_DEPTH  IO word address.
- IO_WD  in  32  write data.
- SW  in  N_SW  raw asynchronous switch levels.
- BTN  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- IO_RD  out  32  registered read data.

Behaviour:
- Request capture: IO_REQ, DBE, IO_WE, IO_RE, IO_ADDR and IO_WD are registered at edge N.
  - req_valid = ioreq_q & ~dbe_q.
  - Read hit = req_valid & iore_q. Write hit = req_valid & iowe_q.
- Read latency: IO_RD updates at edge N+1 and holds until the next read hit. Non-read cycles do not change IO_RD.
- Address map (addr_q):
  - 0: reserved, reads 0 (LED register is write-only).
  - 1: {zero-ext, sw_deb}.
  - 2: {zero-ext, btn_deb}.
  - 3: {zero-ext, btn_evt}.
  - 4: tick counter.
  - Any other address reads 0x0000_0000 with no side effects.
- Input conditioning, per bit:
  - 2-flop synchronizer, then debounce counter.
  - When sync != stable, the counter increments. When it reaches DEB_CYCLES-1 on a mismatch cycle, stable <= sync and the counter clears.
  - Any cycle with sync == stable clears the counter.
  - Total latency from a clean raw edge to the debounced change: 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles never propagates.
- btn_evt: a bit is set on a 0->1 transition of btn_deb.
  - Read hit at addr 3 clears all bits at edge N+1; IO_RD returns the pre-clear value.
  - Write hit at addr 3 clears the bits where IO_WD[i]=1 (write-1-to-clear).
  - A new rising edge in the same cycle as a clear wins: that bit stays 1.
- Tick counter: 32-bit, increments every cycle, wraps 0xFFFF_FFFF -> 0.
  - Write hit at addr 4 loads wd_q at edge N+1; counting resumes from that value the next cycle.
  - A read returns the value at edge N+1 (pre-increment sample).
- Writes to addresses 1, 2 and 0/unmapped: no effect. Read and write in the same request: the read is served and the write side effect also applies. For addr 3, the union of clears applies; a new edge still wins.
- DBE=1 with IO_REQ: no read update, no clear, no counter load.
- Reset (async assert, sync-safe release): IO_RD=0, all request regs 0, synchronizers 0, stable 0, debounce counters 0, btn_evt 0, tick 0. Assertion mid-debounce or mid-request drops all pending state. No event may be generated from the post-reset 0 level.

Decomposition:
- Shared package io_pkg holds:
  - address constants IO_ADDR_LEDS=0, IO_ADDR_SW=1, IO_ADDR_BTN=2, IO_ADDR_BTNEVT=3, IO_ADDR_TICK=4;
  - the read-data-on-miss constant 0.
- One sub-module, io_debounce:
  - parameters W and DEB_CYCLES;
  - inputs CLK, RESET and raw[W];
  - output stable[W];
  - contains the synchronizer and per-bit counters.
  - Instantiated twice: switches and buttons.
- Registers use the existing ffd flop cell where practical.

Test Plan:
- Reset then read addr 4 with no writes: IO_RD equals the cycle count since reset release, consistent with the pre-increment sample rule. Write 0xFFFF_FFFE to addr 4, then read twice, 1 cycle apart: reads 0xFFFF_FFFF then 0x0000_0000.
- DEB_CYCLES=4, SW=0xA5 held steady: read addr 1 before 6 cycles -> 0x00, after 6 cycles -> 0x0000_00A5. Toggle SW[0] for 3 cycles: debounced value unchanged.
- BTN[2] press held 10 cycles, then released: read addr 3 -> 0x4, re-read -> 0x0. Read addr 2 during the press -> 0x4.
- BTN[1] debounced rising edge lands in the same cycle as the addr-3 read-clear: the first read returns the old value without bit 1; the next read returns 0x2.
- Read addr 1 with DBE=1: IO_RD keeps its previous value. Write 0x1 to addr 3 while btn_evt=0x5: the next read gives 0x4.
- Read addr 0x3FFF and addr 0: both return 0. Assert RESET mid-debounce: IO_RD=0 and btn_evt=0, and no event appears after release with BTN held low.
